// File: rtl/simon_round_sequencer.sv
// rtl/simon_round_sequencer.sv - Simon game round controller: pattern growth, tick-timed show, echo check.
module simon_round_sequencer #(
  parameter int unsigned MAX_ROUNDS    = 8,
  parameter int unsigned ON_TICKS      = 2,
  parameter int unsigned OFF_TICKS     = 1,
  parameter int unsigned TIMEOUT_TICKS = 10,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [3:0] display_bits,
  output logic       showing,
  output logic       led,
  output logic       play,
  output logic       win,
  output logic       lose,
  output logic [4:0] round
);

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_SHOW_ON, S_SHOW_OFF, S_READ, S_WIN, S_LOSE
  } state_t;

  localparam logic [15:0] ON_LAST  = 16'(ON_TICKS - 1);
  localparam logic [15:0] OFF_LAST = 16'(OFF_TICKS - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_TICKS - 1);
  localparam logic [4:0]  MAXR     = 5'(MAX_ROUNDS);

  state_t      state_q;
  logic [7:0]  lfsr_q;
  logic [1:0]  pat_q [16];
  logic [4:0]  round_q;
  logic [3:0]  idx_q;
  logic [15:0] tcnt_q;
  logic [3:0]  disp_q;
  logic        showing_q, led_q, play_q, win_q, lose_q;

  logic        lfsr_fb;
  logic [3:0]  idx_nxt;
  logic        idx_last;

  assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign idx_nxt  = idx_q + 4'd1;
  assign idx_last = ({1'b0, idx_q} == (round_q - 5'd1));

  function automatic logic [3:0] dec(input logic [1:0] p);
    return 4'b1000 >> p;
  endfunction

  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_SEED;
      round_q   <= '0;
      idx_q     <= '0;
      tcnt_q    <= '0;
      disp_q    <= '0;
      showing_q <= 1'b0;
      led_q     <= 1'b0;
      play_q    <= 1'b0;
      win_q     <= 1'b0;
      lose_q    <= 1'b0;
      for (int i = 0; i < 16; i++) pat_q[i] <= '0;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_fb};
      play_q <= 1'b0;
      case (state_q)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            state_q <= S_GEN;
            round_q <= '0;
            idx_q   <= '0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
          end
        end
        S_GEN: begin
          // On the first round pattern[0] is written this cycle, so show the fresh LFSR bits directly.
          pat_q[round_q[3:0]] <= lfsr_q[1:0];
          round_q   <= round_q + 5'd1;
          idx_q     <= '0;
          tcnt_q    <= '0;
          state_q   <= S_SHOW_ON;
          showing_q <= 1'b1;
          disp_q    <= dec((round_q == 5'd0) ? lfsr_q[1:0] : pat_q[0]);
        end
        S_SHOW_ON: begin
          if (tick) begin
            if (tcnt_q == ON_LAST) begin
              tcnt_q  <= '0;
              state_q <= S_SHOW_OFF;
              disp_q  <= '0;
            end else begin
              tcnt_q <= tcnt_q + 16'd1;
            end
          end
        end
        S_SHOW_OFF: begin
          if (tick) begin
            if (tcnt_q == OFF_LAST) begin
              tcnt_q <= '0;
              if (idx_last) begin
                state_q   <= S_READ;
                idx_q     <= '0;
                showing_q <= 1'b0;
                led_q     <= 1'b1;
              end else begin
                idx_q   <= idx_nxt;
                state_q <= S_SHOW_ON;
                disp_q  <= dec(pat_q[idx_nxt]);
              end
            end else begin
              tcnt_q <= tcnt_q + 16'd1;
            end
          end
        end
        S_READ: begin
          // A press takes priority; a tick arriving with it is dropped.
          if (btn != 4'b0000) begin
            if (btn == dec(pat_q[idx_q])) begin
              play_q <= 1'b1;
              tcnt_q <= '0;
              if (idx_last) begin
                led_q <= 1'b0;
                idx_q <= '0;
                if (round_q == MAXR) begin
                  state_q <= S_WIN;
                  win_q   <= 1'b1;
                end else begin
                  state_q <= S_GEN;
                end
              end else begin
                idx_q <= idx_nxt;
              end
            end else begin
              state_q <= S_LOSE;
              lose_q  <= 1'b1;
              led_q   <= 1'b0;
            end
          end else if (tick) begin
            if (tcnt_q == TO_LAST) begin
              state_q <= S_LOSE;
              lose_q  <= 1'b1;
              led_q   <= 1'b0;
            end else begin
              tcnt_q <= tcnt_q + 16'd1;
            end
          end
        end
        default: begin
          state_q   <= S_IDLE;
          disp_q    <= '0;
          showing_q <= 1'b0;
          led_q     <= 1'b0;
          win_q     <= 1'b0;
          lose_q    <= 1'b0;
        end
      endcase
    end
  end

  assign display_bits = disp_q;
  assign showing      = showing_q;
  assign led          = led_q;
  assign play         = play_q;
  assign win          = win_q;
  assign lose         = lose_q;
  assign round        = round_q;

endmodule
